// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: operation mode encodings and
// helpers that derive and validate the segmented pipeline geometry.
package arith_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int calc_stages(input int width, input int seg_width);
        if (seg_width < 1) begin
            return 1;
        end else begin
            return width / seg_width;
        end
    endfunction

    function automatic bit params_legal(input int width, input int seg_width);
        if (seg_width < 1 || width < 1) begin
            return 1'b0;
        end else if ((width % seg_width) != 0) begin
            return 1'b0;
        end else begin
            return 1'b1;
        end
    endfunction

endpackage

// File: rtl/adder_segment.sv
// Combinational SEG_WIDTH-bit adder slice with carry in and carry out,
// one instance per pipeline stage of pipelined_adder.
module adder_segment #(
    parameter int SEG_WIDTH = 8
) (
    input  logic [SEG_WIDTH-1:0] a,
    input  logic [SEG_WIDTH-1:0] b,
    input  logic                 cin,
    output logic [SEG_WIDTH-1:0] s,
    output logic                 cout
);

    logic [SEG_WIDTH:0] w_sum;

    assign w_sum = {1'b0, a} + {1'b0, b} + {{SEG_WIDTH{1'b0}}, cin};
    assign s     = w_sum[SEG_WIDTH-1:0];
    assign cout  = w_sum[SEG_WIDTH];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined adder/subtractor: one SEG_WIDTH segment is added per stage with
// the carry registered in between; a global advance stalls all stages together.
module pipelined_adder
    import arith_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int SEG_WIDTH = 8,
    parameter int STAGES    = calc_stages(WIDTH, SEG_WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_in,
    input  logic             SUB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             C_out,
    output logic             OVF
);

    localparam int MSB = WIDTH - 1;

    if (!params_legal(WIDTH, SEG_WIDTH) || STAGES != calc_stages(WIDTH, SEG_WIDTH)) begin : g_param_check
        $error("pipelined_adder: WIDTH must be a positive multiple of SEG_WIDTH and STAGES must not be overridden");
    end

    logic             w_adv;
    logic [WIDTH-1:0] w_beff;
    logic             w_cin0;

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    // Operand conditioning: subtraction is A + ~B + 1.
    always_comb begin
        w_beff = B;
        w_cin0 = C_in;
        if (SUB == MODE_SUB) begin
            w_beff = ~B;
            w_cin0 = 1'b1;
        end else begin
            w_beff = B;
            w_cin0 = C_in;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : gen_stage
        logic [WIDTH-1:0]     w_a;
        logic [WIDTH-1:0]     w_b;
        logic [WIDTH-1:0]     w_s_in;
        logic [WIDTH-1:0]     w_s_nxt;
        logic                 w_c_in;
        logic                 w_v_in;
        logic [SEG_WIDTH-1:0] w_seg_s;
        logic                 w_seg_c;
        logic [WIDTH-1:0]     r_a;
        logic [WIDTH-1:0]     r_b;
        logic [WIDTH-1:0]     r_s;
        logic                 r_c;
        logic                 r_v;

        if (k == 0) begin : g_first
            assign w_a    = A;
            assign w_b    = w_beff;
            assign w_s_in = {WIDTH{1'b0}};
            assign w_c_in = w_cin0;
            assign w_v_in = in_valid;
        end else begin : g_next
            assign w_a    = gen_stage[k-1].r_a;
            assign w_b    = gen_stage[k-1].r_b;
            assign w_s_in = gen_stage[k-1].r_s;
            assign w_c_in = gen_stage[k-1].r_c;
            assign w_v_in = gen_stage[k-1].r_v;
        end

        adder_segment #(
            .SEG_WIDTH (SEG_WIDTH)
        ) u_seg (
            .a    (w_a[k*SEG_WIDTH +: SEG_WIDTH]),
            .b    (w_b[k*SEG_WIDTH +: SEG_WIDTH]),
            .cin  (w_c_in),
            .s    (w_seg_s),
            .cout (w_seg_c)
        );

        // Merge this stage's sum segment into the result accumulated so far.
        always_comb begin
            w_s_nxt = w_s_in;
            w_s_nxt[k*SEG_WIDTH +: SEG_WIDTH] = w_seg_s;
        end

        // Stage register: operands travel whole so the MSBs reach the overflow logic.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_a <= {WIDTH{1'b0}};
                r_b <= {WIDTH{1'b0}};
                r_s <= {WIDTH{1'b0}};
                r_c <= 1'b0;
                r_v <= 1'b0;
            end else if (w_adv) begin
                r_a <= w_a;
                r_b <= w_b;
                r_s <= w_s_nxt;
                r_c <= w_seg_c;
                r_v <= w_v_in;
            end else begin
                r_a <= r_a;
                r_b <= r_b;
                r_s <= r_s;
                r_c <= r_c;
                r_v <= r_v;
            end
        end
    end

    assign out_valid = gen_stage[STAGES-1].r_v;
    assign S         = gen_stage[STAGES-1].r_s;
    assign C_out     = gen_stage[STAGES-1].r_c;
    assign OVF       = (gen_stage[STAGES-1].r_a[MSB] == gen_stage[STAGES-1].r_b[MSB]) &&
                       (gen_stage[STAGES-1].r_s[MSB] != gen_stage[STAGES-1].r_a[MSB]);

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed self-checking bench for pipelined_adder at WIDTH=32, SEG_WIDTH=8.
module tb_pipelined_adder;

    localparam int LAT = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        C_in;
    logic        SUB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] S;
    logic        C_out;
    logic        OVF;

    int n_cmp  = 0;
    int n_fail = 0;

    pipelined_adder #(
        .WIDTH     (32),
        .SEG_WIDTH (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .C_in      (C_in),
        .SUB       (SUB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .C_out     (C_out),
        .OVF       (OVF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one beat (caller sits at a negedge with in_ready high).
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
        in_valid = 1'b1;
        A        = a;
        B        = b;
        C_in     = cin;
        SUB      = sub;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Cycles from accept edge until out_valid; -1 when the bound expires.
    task automatic wait_out(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid: got %b expected 0", out_valid); end
        n_cmp++; if (S !== 32'h0) begin n_fail++; $display("FAIL rst_async_s: got %h expected 00000000", S); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
        n_cmp++; if (S !== 32'h0) begin n_fail++; $display("FAIL rst_s: got %h expected 00000000", S); end
        n_cmp++; if (C_out !== 1'b0) begin n_fail++; $display("FAIL rst_cout: got %b expected 0", C_out); end
        n_cmp++; if (OVF !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b expected 0", OVF); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_carry_ripple();
        int lat;
        @(negedge clk);
        issue(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        wait_out(lat);
        n_cmp++; if (lat != LAT) begin n_fail++; $display("FAIL ripple_latency: got %0d expected %0d", lat, LAT); end
        n_cmp++; if (S !== 32'h0000_0100) begin n_fail++; $display("FAIL ripple_s: got %h expected 00000100", S); end
        n_cmp++; if (C_out !== 1'b0) begin n_fail++; $display("FAIL ripple_cout: got %b expected 0", C_out); end
        n_cmp++; if (OVF !== 1'b0) begin n_fail++; $display("FAIL ripple_ovf: got %b expected 0", OVF); end
    endtask

    task automatic test_full_wrap();
        int lat;
        @(negedge clk);
        issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        wait_out(lat);
        n_cmp++; if (lat != LAT) begin n_fail++; $display("FAIL wrap_latency: got %0d expected %0d", lat, LAT); end
        n_cmp++; if (S !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_s: got %h expected 00000000", S); end
        n_cmp++; if (C_out !== 1'b1) begin n_fail++; $display("FAIL wrap_cout: got %b expected 1", C_out); end
        n_cmp++; if (OVF !== 1'b0) begin n_fail++; $display("FAIL wrap_ovf: got %b expected 0", OVF); end
        @(negedge clk);
        issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        wait_out(lat);
        n_cmp++; if (S !== 32'h8000_0000) begin n_fail++; $display("FAIL posovf_s: got %h expected 80000000", S); end
        n_cmp++; if (C_out !== 1'b0) begin n_fail++; $display("FAIL posovf_cout: got %b expected 0", C_out); end
        n_cmp++; if (OVF !== 1'b1) begin n_fail++; $display("FAIL posovf_ovf: got %b expected 1", OVF); end
    endtask

    task automatic test_subtract();
        int lat;
        @(negedge clk);
        issue(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
        wait_out(lat);
        n_cmp++; if (lat != LAT) begin n_fail++; $display("FAIL sub_latency: got %0d expected %0d", lat, LAT); end
        n_cmp++; if (S !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL sub_s: got %h expected fffffffe", S); end
        n_cmp++; if (C_out !== 1'b0) begin n_fail++; $display("FAIL sub_cout: got %b expected 0", C_out); end
        n_cmp++; if (OVF !== 1'b0) begin n_fail++; $display("FAIL sub_ovf: got %b expected 0", OVF); end
        @(negedge clk);
        issue(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
        wait_out(lat);
        n_cmp++; if (S !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL subovf_s: got %h expected 7fffffff", S); end
        n_cmp++; if (C_out !== 1'b1) begin n_fail++; $display("FAIL subovf_cout: got %b expected 1", C_out); end
        n_cmp++; if (OVF !== 1'b1) begin n_fail++; $display("FAIL subovf_ovf: got %b expected 1", OVF); end
    endtask

    task automatic test_back_to_back();
        int got;
        got = 0;
        @(negedge clk);
        out_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready c=%0d: got %b expected 1", c, in_ready); end
            if (c >= LAT && c < LAT + 8) begin
                n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid c=%0d: got %b expected 1", c, out_valid); end
                n_cmp++; if (S !== 32'(2 * (c - LAT))) begin n_fail++; $display("FAIL b2b_s c=%0d: got %h expected %h", c, S, 32'(2 * (c - LAT))); end
                if (out_valid === 1'b1) got++;
            end else begin
                n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle c=%0d: got %b expected 0", c, out_valid); end
            end
            if (c < 8) begin
                in_valid = 1'b1;
                A        = 32'(c);
                B        = 32'(c);
                C_in     = 1'b0;
                SUB      = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        n_cmp++; if (got != 8) begin n_fail++; $display("FAIL b2b_count: got %0d expected 8", got); end
    endtask

    task automatic test_backpressure();
        logic [32:0] exp_q[$];
        logic [32:0] exp_v;
        logic [31:0] held;
        int sent;
        int recv;
        sent = 0;
        recv = 0;
        held = 32'h0;
        @(negedge clk);
        for (int c = 0; c < 60 && recv < 12; c++) begin
            out_ready = !(c >= 6 && c < 9);
            if (sent < 12) begin
                in_valid = 1'b1;
                A        = 32'hFFFF_FF00 + 32'(sent * 16);
                B        = 32'h0000_0180 + 32'(sent);
                C_in     = 1'b0;
                SUB      = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c >= 6 && c < 9) begin
                n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready c=%0d: got %b expected 0", c, in_ready); end
                n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid c=%0d: got %b expected 1", c, out_valid); end
                if (c == 6) begin
                    held = S;
                end else begin
                    n_cmp++; if (S !== held) begin n_fail++; $display("FAIL bp_hold c=%0d: got %h expected %h", c, S, held); end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({1'b0, A} + {1'b0, B});
                sent++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL bp_extra: got beat %h expected none", S);
                end else begin
                    exp_v = exp_q.pop_front();
                    n_cmp++; if (S !== exp_v[31:0]) begin n_fail++; $display("FAIL bp_s beat %0d: got %h expected %h", recv, S, exp_v[31:0]); end
                    n_cmp++; if (C_out !== exp_v[32]) begin n_fail++; $display("FAIL bp_cout beat %0d: got %b expected %b", recv, C_out, exp_v[32]); end
                end
                recv++;
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_cmp++; if (recv != 12) begin n_fail++; $display("FAIL bp_recv: got %0d expected 12", recv); end
        n_cmp++; if (sent != 12) begin n_fail++; $display("FAIL bp_sent: got %0d expected 12", sent); end
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_left: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_midstream();
        int lat;
        @(negedge clk);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            A        = 32'h1111_1111 * 32'(c + 1);
            B        = 32'h0101_0101;
            C_in     = 1'b0;
            SUB      = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || S !== 32'h1212_1212) begin n_fail++; $display("FAIL mid_pre: got %b/%h expected 1/12121212", out_valid, S); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b expected 0", out_valid); end
        n_cmp++; if (S !== 32'h0) begin n_fail++; $display("FAIL mid_rst_s: got %h expected 00000000", S); end
        n_cmp++; if (C_out !== 1'b0 || OVF !== 1'b0) begin n_fail++; $display("FAIL mid_rst_flags: got %b%b expected 00", C_out, OVF); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale c=%0d: got %b expected 0", c, out_valid); end
        end
        issue(32'h0000_1234, 32'h0000_0001, 1'b0, 1'b0);
        wait_out(lat);
        n_cmp++; if (lat != LAT) begin n_fail++; $display("FAIL mid_latency: got %0d expected %0d", lat, LAT); end
        n_cmp++; if (S !== 32'h0000_1235) begin n_fail++; $display("FAIL mid_s: got %h expected 00001235", S); end
    endtask

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = 32'h0;
        B         = 32'h0;
        C_in      = 1'b0;
        SUB       = 1'b0;
        test_reset();
        test_carry_ripple();
        test_full_wrap();
        test_subtract();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined two-operand adder/subtractor, successor to the fixed-width combinational ripple adders in the arithmetic library.
- Splits a WIDTH-bit operation into SEG_WIDTH-bit segments, one segment per pipeline stage, with the carry registered between stages.
- Sustains one operation per cycle; valid/ready handshakes on both sides let it sit between streaming producers and consumers in the datapath.

Parameters:
- WIDTH, 32, operand and sum width; must be a multiple of SEG_WIDTH.
- SEG_WIDTH, 8, bits added per pipeline stage.
- STAGES, WIDTH/SEG_WIDTH, derived pipeline depth; do not override.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat this cycle
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- C_in  in  1  carry-in; used only when SUB=0
- SUB  in  1  0: S=A+B+C_in; 1: S=A-B (C_in ignored)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- S  out  WIDTH  sum/difference
- C_out  out  1  carry-out (for SUB: 1 = no borrow)
- OVF  out  1  signed two's-complement overflow

Behaviour:
- Interface decided: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: out_valid=0, S=0, C_out=0, OVF=0. All stage valid bits and all pipeline data registers clear to 0.
- Reset mid-operation drops all in-flight beats; none emerge after reset deasserts.
- in_ready is 1 out of reset.
- Transfer rules:
  - Input beat accepted on a cycle with in_valid && in_ready.
  - Output beat consumed on a cycle with out_valid && out_ready.
- Global advance: adv = !out_valid || out_ready. in_ready = adv (combinational from out_ready).
  - When adv=0, every stage holds.
  - Bubbles are not compacted.
- Operand conditioning at accept:
  - Beff = SUB ? ~B : B.
  - cin0 = SUB ? 1 : C_in.
- Stage k (0..STAGES-1) adds segment k of A and Beff plus the carry from stage k-1 (cin0 for k=0).
  - It registers sum segment k and carry k.
  - Upper, not-yet-added operand segments travel with the beat.
  - Lower result segments are carried forward, so the full result is aligned at the last stage.
- Latency: beat accepted in cycle t with no stall → out_valid=1 in cycle t+STAGES. Throughput is 1 beat/cycle.
- The valid bit travels with the beat; data registers may load on adv regardless of valid.
- C_out = carry out of the MSB segment.
- OVF = (A[MSB]==Beff[MSB]) && (S[MSB]!=A[MSB]).
  - OVF must use the MSB of the original A and Beff, so both travel to the last stage.
- Wrap-around: the sum is modulo 2^WIDTH; C_out carries the overflow bit.
- Simultaneous accept and drain on the same cycle is legal and keeps a full pipeline moving.
- S, C_out and OVF hold stable while out_valid && !out_ready.
- Elaboration error if WIDTH % SEG_WIDTH != 0 or SEG_WIDTH < 1.
- STAGES=1 degenerates to a single registered adder with latency 1.

Decomposition:
- Shared package arith_pkg:
  - Mode encodings: MODE_ADD=1'b0, MODE_SUB=1'b1.
  - Function for the STAGES derivation and the parameter legality check.
- One sub-module: adder_segment, a combinational SEG_WIDTH-bit adder.
  - Inputs: a, b, cin. Outputs: s, cout.
  - Instantiated STAGES times via generate.
- Pipeline registers, handshake and the overflow logic live in the top module.

Test Plan (WIDTH=32, SEG_WIDTH=8, latency 4):
- Carry ripple: A=0x000000FF, B=0x00000001, C_in=0, SUB=0 → 4 cycles later S=0x00000100, C_out=0, OVF=0.
- Full wrap: A=0xFFFFFFFF, B=0x00000000, C_in=1 → S=0x00000000, C_out=1. Then A=0x7FFFFFFF, B=1, C_in=0 → S=0x80000000, OVF=1.
- Subtract: A=5, B=7, SUB=1, C_in=1 (ignored) → S=0xFFFFFFFE, C_out=0. Then A=0x80000000, B=1, SUB=1 → S=0x7FFFFFFF, OVF=1, C_out=1.
- Streaming: 8 back-to-back beats A=i, B=i, out_ready=1 → results 0,2,…,14 on consecutive cycles starting 4 cycles after the first accept; in_ready stays 1.
- Backpressure: fill the pipe, hold out_ready=0 for 3 cycles.
  - Required: in_ready=0 and S held stable during the stall.
  - Required: no beat lost or duplicated; order preserved after release.
- Reset mid-stream: assert rst_n=0 with 3 beats in flight → out_valid=0 and S=0 immediately (async); after release no stale beat appears and the first new beat returns after 4 cycles.
